// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared definitions for the round-robin ALU scheduler.
//   - opcode encodings OP_AND .. OP_MUL (1011-1111 are illegal)
//   - FSM state enum (IDLE / MUL / RESP)
//   - MUL_ITERS: number of Booth iterations for a 16-bit multiply
package alu_sched_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_LSL  = 4'b0110;
  localparam logic [3:0] OP_LSR  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  localparam int MUL_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, signed x signed.
// One add/sub plus arithmetic right shift per clock, DATA_W iterations.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load operands, clear the iteration counter, begin
//   a          multiplicand (signed)
//   b          multiplier (signed)
//   done       high once the last iteration has completed (held until next start)
//   product    2*DATA_W signed product, valid while done is high
module booth_mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // p_r = {A, Q, q_-1}: accumulator, multiplier, Booth history bit
  logic [2*DATA_W:0]  p_r;
  logic [DATA_W-1:0]  m_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;

  logic [DATA_W:0]    acc_ext_s;
  logic [DATA_W:0]    m_ext_s;
  logic [DATA_W:0]    sum_s;

  // Booth step: the add/sub is one bit wider than A so that subtracting the
  // most negative multiplicand cannot overflow; that extra bit becomes the
  // sign shifted into A.
  always_comb begin
    acc_ext_s = {p_r[2*DATA_W], p_r[2*DATA_W:DATA_W+1]};
    m_ext_s   = {m_r[DATA_W-1], m_r};
    case (p_r[1:0])
      2'b01:   sum_s = acc_ext_s + m_ext_s;
      2'b10:   sum_s = acc_ext_s - m_ext_s;
      default: sum_s = acc_ext_s;
    endcase
  end

  // Product/multiplier register, iteration counter and completion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r    <= '0;
      m_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      p_r    <= {{DATA_W{1'b0}}, b, 1'b0};
      m_r    <= a;
      cnt_r  <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      // arithmetic shift right of {sum, Q, q_-1}, dropping q_-1
      p_r <= {sum_s, p_r[DATA_W:1]};
      if (cnt_r == CNT_LAST) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign done    = done_r;
  assign product = p_r[2*DATA_W:1];

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: one ALU shared by two requesters with round-robin
// arbitration. Single-cycle logic/shift/add/sub ops respond the cycle after
// accept; MUL uses the sequential Booth multiplier (booth_mul_seq).
// Optional feature macro: ALU_OVF_FLAG_EN (signed ADD/SUB overflow flag;
// on overflow the result is forced to 0). Undefined: rsp_ovf is always 0.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   reqN_valid/ready               requester N handshake (ready only in IDLE)
//   reqN_op, reqN_a, reqN_b        opcode and operands, captured on accept
//   rsp_valid/rsp_ready            response handshake
//   rsp_id                         requester that issued the op
//   rsp_result                     2*DATA_W result (16-bit ops sign-extended)
//   rsp_err                        illegal opcode
//   rsp_ovf                        signed ADD/SUB overflow (optional feature)
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int RR_RESET_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [3:0]          req0_op,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [3:0]          req1_op,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic                rsp_err,
  output logic                rsp_ovf
);

  // last_grant resets to the requester that should lose the first tie
  localparam logic GRANT_RST = (RR_RESET_PRIO == 0) ? 1'b1 : 1'b0;
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W[DATA_W-1:0];

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  last_grant_r;

  logic                  grant0_s;
  logic                  grant1_s;
  logic                  accept_s;
  logic                  sel_id_s;
  logic [3:0]            sel_op_s;
  logic [DATA_W-1:0]     sel_a_s;
  logic [DATA_W-1:0]     sel_b_s;
  logic                  sel_mul_s;

  logic [DATA_W-1:0]     b_eff_s;
  logic                  carry_in_s;
  logic [DATA_W-1:0]     sum_s;
  logic [DATA_W-1:0]     alu_res_s;
  logic [2*DATA_W-1:0]   alu_result_s;
  logic                  alu_err_s;
  logic                  alu_ovf_s;

  logic                  mul_start_s;
  logic                  mul_done_s;
  logic [2*DATA_W-1:0]   mul_product_s;

  logic                  rsp_valid_r;
  logic                  rsp_id_r;
  logic [2*DATA_W-1:0]   rsp_result_r;
  logic                  rsp_err_r;
  logic                  rsp_ovf_r;

  // Ready is a combinational function of valid so a lone requester is taken
  // in the same cycle; the last_grant term makes the two grants exclusive.
  assign grant0_s   = (state_r == IDLE) & req0_valid & (~req1_valid | last_grant_r);
  assign grant1_s   = (state_r == IDLE) & req1_valid & (~req0_valid | ~last_grant_r);
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign accept_s   = grant0_s | grant1_s;

  // Operand/opcode mux for the granted requester
  always_comb begin
    if (grant1_s) begin
      sel_id_s = 1'b1;
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_id_s = 1'b0;
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  assign sel_mul_s   = (sel_op_s == OP_MUL);
  assign mul_start_s = accept_s & sel_mul_s;

  // Single-cycle ALU; SUB reuses the adder as a + ~b + 1
  always_comb begin
    alu_res_s = '0;
    alu_err_s = 1'b0;
    alu_ovf_s = 1'b0;
    if (sel_op_s == OP_SUB) begin
      b_eff_s    = ~sel_b_s;
      carry_in_s = 1'b1;
    end else begin
      b_eff_s    = sel_b_s;
      carry_in_s = 1'b0;
    end
    sum_s = sel_a_s + b_eff_s + {{(DATA_W-1){1'b0}}, carry_in_s};
    case (sel_op_s)
      OP_AND:  alu_res_s = sel_a_s & sel_b_s;
      OP_OR:   alu_res_s = sel_a_s | sel_b_s;
      OP_NAND: alu_res_s = ~(sel_a_s & sel_b_s);
      OP_NOR:  alu_res_s = ~(sel_a_s | sel_b_s);
      OP_XOR:  alu_res_s = sel_a_s ^ sel_b_s;
      OP_XNOR: alu_res_s = ~(sel_a_s ^ sel_b_s);
      OP_LSL: begin
        if (sel_b_s >= SHIFT_LIM) begin
          alu_res_s = '0;
        end else begin
          alu_res_s = sel_a_s << sel_b_s;
        end
      end
      OP_LSR: begin
        if (sel_b_s >= SHIFT_LIM) begin
          alu_res_s = '0;
        end else begin
          alu_res_s = sel_a_s >> sel_b_s;
        end
      end
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s;
`ifdef ALU_OVF_FLAG_EN
        // operands of equal sign producing a sum of the other sign
        if ((sel_a_s[DATA_W-1] == b_eff_s[DATA_W-1]) &&
            (sum_s[DATA_W-1] != sel_a_s[DATA_W-1])) begin
          alu_ovf_s = 1'b1;
          alu_res_s = '0;
        end else begin
          alu_ovf_s = 1'b0;
        end
`endif
      end
      OP_MUL:  alu_res_s = '0;
      default: begin
        alu_err_s = 1'b1;
        alu_res_s = '0;
      end
    endcase
    alu_result_s = {{DATA_W{alu_res_s[DATA_W-1]}}, alu_res_s};
  end

  booth_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (sel_a_s),
    .b       (sel_b_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (sel_mul_s) begin
            state_nxt_s = MUL;
          end else begin
            state_nxt_s = RESP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = MUL;
        end
      end
      RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Round-robin pointer: remembers the requester served most recently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= GRANT_RST;
    end else if (accept_s) begin
      last_grant_r <= sel_id_s;
    end
  end

  // Response registers: loaded on single-cycle accept or MUL completion,
  // frozen while waiting for the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= '0;
      rsp_err_r    <= 1'b0;
      rsp_ovf_r    <= 1'b0;
    end else if ((state_r == IDLE) && accept_s) begin
      rsp_id_r <= sel_id_s;
      if (!sel_mul_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_result_r <= alu_result_s;
        rsp_err_r    <= alu_err_s;
        rsp_ovf_r    <= alu_ovf_s;
      end
    end else if ((state_r == MUL) && mul_done_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_result_r <= mul_product_s;
      rsp_err_r    <= 1'b0;
      rsp_ovf_r    <= 1'b0;
    end else if (rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_err    = rsp_err_r;
  assign rsp_ovf    = rsp_ovf_r;

endmodule
